// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port, synchronous-read data memory between the CPU
// control path (read/write) and the DBG reader (read-only). The winning request is
// registered onto the memory bus. Read data returns with a one-cycle rvalid pulse.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration. When the macro is
// undefined, the CPU has fixed priority and a streak guard ensures DBG makes progress.
module mem_port_arbiter #(
  parameter int unsigned AW             = 8,
  parameter int unsigned DW             = 8,
  parameter int unsigned CPU_STREAK_MAX = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] ADD,
  output logic [DW-1:0] DATA_IN,
  output logic          WRITE_EN,
  output logic          MEM_EN,
  input  logic [DW-1:0] D_OUT,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StRwait} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] add_q, add_d;
  logic [DW-1:0] din_q, din_d;
  logic          we_q, we_d;
  logic          en_q, en_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          dbg_gnt_q, dbg_gnt_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          win_dbg_q, win_dbg_d;   // owner of the access in flight
  logic          pick_dbg;

`ifdef MEM_ARB_RR_EN
  logic last_dbg_q, last_dbg_d;

  // On a tie, the port that did not win last time wins now.
  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);

  // Track which port won the most recent grant.
  always_comb begin
    last_dbg_d = last_dbg_q;
    if (state_q == StIdle && (cpu_req || dbg_req)) last_dbg_d = pick_dbg;
  end

  // Register the last winner. Reset to DBG so that the CPU wins the first tie.
  always_ff @(posedge CLK) begin
    if (RESET) last_dbg_q <= 1'b1;
    else       last_dbg_q <= last_dbg_d;
  end
`else
  localparam logic [3:0] StreakMax = 4'(CPU_STREAK_MAX);
  logic [3:0] streak_q, streak_d;

  // CPU has priority until it has taken StreakMax grants past a waiting DBG request.
  assign pick_dbg = dbg_req & (~cpu_req | (streak_q == StreakMax));

  // Count CPU grants made while DBG waits. Clear on a DBG grant or an idle DBG.
  always_comb begin
    streak_d = streak_q;
    if (state_q == StIdle) begin
      if (!dbg_req || pick_dbg)                   streak_d = '0;
      else if (cpu_req && streak_q < StreakMax)   streak_d = streak_q + 4'd1;
    end
  end

  // Register the streak counter.
  always_ff @(posedge CLK) begin
    if (RESET) streak_q <= '0;
    else       streak_q <= streak_d;
  end
`endif

  // Compute next-state logic and the next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    add_d        = add_q;
    din_d        = din_q;
    we_d         = 1'b0;
    en_d         = 1'b0;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    win_dbg_d    = win_dbg_q;
    case (state_q)
      StIdle: begin
        if (cpu_req || dbg_req) begin
          state_d   = StIssue;
          en_d      = 1'b1;
          win_dbg_d = pick_dbg;
          if (pick_dbg) begin
            add_d     = dbg_addr;
            dbg_gnt_d = 1'b1;
          end else begin
            add_d     = cpu_addr;
            din_d     = cpu_wdata;
            we_d      = cpu_we;
            cpu_gnt_d = 1'b1;
          end
        end
      end
      StIssue: state_d = we_q ? StIdle : StRwait;
      StRwait: begin
        // D_OUT is valid now, one cycle after the read strobe.
        state_d = StIdle;
        if (win_dbg_q) begin
          dbg_rdata_d  = D_OUT;
          dbg_rvalid_d = 1'b1;
        end else begin
          cpu_rdata_d  = D_OUT;
          cpu_rvalid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register the state and all outputs. Reset drops any read that is in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      add_q        <= '0;
      din_q        <= '0;
      we_q         <= 1'b0;
      en_q         <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      win_dbg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      add_q        <= add_d;
      din_q        <= din_d;
      we_q         <= we_d;
      en_q         <= en_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      win_dbg_q    <= win_dbg_d;
    end
  end

  assign ADD        = add_q;
  assign DATA_IN    = din_q;
  assign WRITE_EN   = we_q;
  assign MEM_EN     = en_q;
  assign cpu_gnt    = cpu_gnt_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port, synchronous-read data memory between two requesters: the processor control path (CPU port) and the display/debug reader (DBG port, read-only). It registers the winning request onto the memory bus (ADD, DATA_IN, WRITE_EN, MEM_EN), returns read data with a valid pulse, and guarantees DBG progress under continuous CPU traffic. It sits between the processor FSM and the memory, replacing direct FSM drive of the memory pins.

Parameters:
AW, 8, address width (ADD, cpu_addr, dbg_addr)
DW, 8, data width (DATA_IN, D_OUT, cpu_wdata, cpu_rdata, dbg_rdata)
CPU_STREAK_MAX, 4, consecutive CPU grants allowed while dbg_req is pending; legal range 1..15

Ports:
CLK  in  1  clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_gnt seen
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req=1
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  one-cycle grant pulse
cpu_rvalid  out  1  one-cycle read-data-valid pulse
cpu_rdata  out  DW  registered read data, held until next CPU read
dbg_req  in  1  DBG read request; held until dbg_gnt seen
dbg_addr  in  AW  DBG address
dbg_gnt  out  1  one-cycle grant pulse
dbg_rvalid  out  1  one-cycle read-data-valid pulse
dbg_rdata  out  DW  registered read data, held until next DBG read
ADD  out  AW  memory address (registered)
DATA_IN  out  DW  memory write data (registered)
WRITE_EN  out  1  memory write enable (registered)
MEM_EN  out  1  memory enable (registered)
D_OUT  in  DW  memory read data, valid the cycle after MEM_EN=1, WRITE_EN=0
busy  out  1  1 whenever state is not IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; streak counter 0; any in-flight read discarded, no rvalid issued afterwards.
- States: IDLE, ISSUE, RWAIT.
- IDLE: if any req is high, pick a winner, register its address/data/we onto ADD/DATA_IN/WRITE_EN, set MEM_EN=1 and the winner's gnt=1 for the next cycle, and go to ISSUE. If no req, stay in IDLE with MEM_EN=0 and WRITE_EN=0.
- ISSUE (1 cycle): MEM_EN=1 and gnt=1 for that cycle only. For a write, go to IDLE. For a read, go to RWAIT.
- RWAIT (1 cycle): MEM_EN=0. At the end of the cycle, capture D_OUT into the winner's rdata, pulse the winner's rvalid=1 in the following cycle (coincident with IDLE), and go to IDLE.
- Latency, from the IDLE cycle in which req is sampled:
  - gnt and MEM_EN at +1.
  - read rvalid at +3.
  - Minimum spacing: 2 cycles per write, 3 cycles per read.
- Requesters drop req on the edge ending their gnt cycle. A req still high in IDLE is treated as a new request.
- Arbitration: CPU has fixed priority. The streak counter increments on each CPU grant made while dbg_req=1 and saturates at CPU_STREAK_MAX. When counter == CPU_STREAK_MAX and dbg_req=1, DBG wins. The counter clears on any DBG grant, and on any IDLE cycle with dbg_req=0.
- DBG is always a read: WRITE_EN=0 on DBG accesses.
- Never two gnts in the same cycle; at most one outstanding access.
- Only one rvalid is high per cycle, and only for the port that was granted.
- ADD and DATA_IN hold their last values when MEM_EN=0.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: round-robin arbitration. A one-bit last-winner register is reset to DBG, so the CPU wins the first tie. When both request in IDLE, the port that did not win last wins. The streak counter is not built and CPU_STREAK_MAX is ignored.
- Undefined: fixed CPU priority with the streak guard, as above.

Test Plan:
- Reset then CPU write addr 0x10, data 0xA5 → cycle+1: cpu_gnt=1, MEM_EN=1, WRITE_EN=1, ADD=0x10, DATA_IN=0xA5; no rvalid.
- CPU read 0x10 with memory model returning 0xA5 → cpu_gnt at +1, cpu_rvalid at +3, cpu_rdata=0xA5, WRITE_EN=0.
- cpu_req and dbg_req held continuously (CPU_STREAK_MAX=4) → grants in order CPU,CPU,CPU,CPU,DBG, repeating; dbg_rvalid follows each dbg_gnt by 2 cycles. With MEM_ARB_RR_EN → order CPU,DBG,CPU,DBG.
- DBG-only read 0x3F with memory returning 0x7E → dbg_gnt at +1, WRITE_EN=0, dbg_rvalid at +3, dbg_rdata=0x7E; cpu_rdata unchanged.
- RESET asserted during RWAIT of a CPU read → next cycle all outputs 0, state IDLE, no cpu_rvalid pulse after reset.
- Stream of 3 CPU writes with req re-raised immediately → gnt every 2 cycles; busy=0 only in the IDLE cycles.
